// File: rtl/vending_coin_feeder.sv
// rtl/vending_coin_feeder.sv - greedy nickel/dime feeder that waits for dispense and reports the outcome
module vending_coin_feeder #(
    parameter int AMOUNT_W = 6,
    parameter int COIN_GAP = 1,
    parameter int TIMEOUT  = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [AMOUNT_W-1:0] req_amount,
    output logic                nickel,
    output logic                dime,
    input  logic                dispense,
    output logic                done_valid,
    output logic                done_ok,
    output logic [AMOUNT_W-1:0] done_coins,
    output logic [AMOUNT_W-1:0] done_spent
);

    typedef enum logic [2:0] {IDLE, COIN, GAP, WAIT, DONE} state_t;

    localparam int CNT_W = 16;
    localparam logic [AMOUNT_W-1:0] AMT_MAX = {AMOUNT_W{1'b1}};

    state_t              state_q, state_d;
    logic [AMOUNT_W-1:0] rem_q, rem_d;
    logic [AMOUNT_W-1:0] coins_q, coins_d;
    logic [AMOUNT_W-1:0] spent_q, spent_d;
    logic [CNT_W-1:0]    cnt_q;
    logic                ok_q;
    logic                nickel_q, dime_q, done_valid_q, req_ready_q;
    logic                accept, take_dime;
    logic [AMOUNT_W-1:0] src, coins_base, spent_base, step;

    assign accept = req_valid && req_ready_q;

    // Next-state selection plus the coin decision for the cycle being entered.
    always_comb begin
        state_d    = state_q;
        src        = (state_q == IDLE) ? req_amount : rem_q;
        coins_base = accept ? '0 : coins_q;
        spent_base = accept ? '0 : spent_q;
        take_dime  = (src >= AMOUNT_W'(2));
        step       = take_dime ? AMOUNT_W'(2) : AMOUNT_W'(1);
        rem_d      = rem_q;
        coins_d    = coins_base;
        spent_d    = spent_base;
        case (state_q)
            IDLE: begin
                if (accept) state_d = (req_amount == '0) ? DONE : COIN;
            end
            COIN: begin
                if (dispense)          state_d = DONE;
                else if (rem_q == '0)  state_d = WAIT;
                else if (COIN_GAP > 0) state_d = GAP;
                else                   state_d = COIN;
            end
            GAP: begin
                if (dispense)                state_d = DONE;
                else if (cnt_q <= CNT_W'(1)) state_d = COIN;
            end
            WAIT: begin
                if (dispense || cnt_q <= CNT_W'(1)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d == COIN) begin
            rem_d   = (src >= step) ? src - step : '0;
            coins_d = (coins_base == AMT_MAX) ? AMT_MAX : coins_base + AMOUNT_W'(1);
            spent_d = (spent_base > AMT_MAX - step) ? AMT_MAX : spent_base + step;
        end
    end

    // State, counters and registered outputs; outputs are derived from the state being entered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            rem_q        <= '0;
            coins_q      <= '0;
            spent_q      <= '0;
            cnt_q        <= '0;
            ok_q         <= 1'b0;
            nickel_q     <= 1'b0;
            dime_q       <= 1'b0;
            done_valid_q <= 1'b0;
            req_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            coins_q      <= coins_d;
            spent_q      <= spent_d;
            req_ready_q  <= (state_d == IDLE);
            done_valid_q <= (state_d == DONE);
            nickel_q     <= (state_d == COIN) && !take_dime;
            dime_q       <= (state_d == COIN) && take_dime;
            if (accept)
                ok_q <= 1'b0;
            if (state_d == DONE)
                ok_q <= (state_q != IDLE) && dispense;
            if (state_d == GAP && state_q != GAP)
                cnt_q <= CNT_W'(COIN_GAP);
            else if (state_d == WAIT && state_q != WAIT)
                cnt_q <= CNT_W'(TIMEOUT);
            else if (cnt_q != '0)
                cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign req_ready  = req_ready_q;
    assign nickel     = nickel_q;
    assign dime       = dime_q;
    assign done_valid = done_valid_q;
    assign done_ok    = ok_q;
    assign done_coins = coins_q;
    assign done_spent = spent_q;

endmodule

// File: tb/tb_vending_coin_feeder.sv
// tb/tb_vending_coin_feeder.sv - table-driven check of vending_coin_feeder with a small machine model
module tb_vending_coin_feeder;

    logic       clock = 1'b0;
    logic       reset;
    logic       req_valid;
    logic [5:0] req_amount;
    logic       dispense;
    logic       sel;

    logic       r1, n1, d1, v1, o1;
    logic [5:0] c1, s1;
    logic       r0, n0, d0, v0, o0;
    logic [5:0] c0, s0;

    logic       req_ready, nickel, dime, done_valid, done_ok;
    logic [5:0] done_coins, done_spent;

    int tests  = 0;
    int failed = 0;

    always #5 clock = ~clock;

    vending_coin_feeder #(.AMOUNT_W(6), .COIN_GAP(1), .TIMEOUT(8)) u_gap1 (
        .clock(clock), .reset(reset), .req_valid(req_valid && !sel), .req_ready(r1),
        .req_amount(req_amount), .nickel(n1), .dime(d1), .dispense(dispense),
        .done_valid(v1), .done_ok(o1), .done_coins(c1), .done_spent(s1)
    );

    vending_coin_feeder #(.AMOUNT_W(6), .COIN_GAP(0), .TIMEOUT(8)) u_gap0 (
        .clock(clock), .reset(reset), .req_valid(req_valid && sel), .req_ready(r0),
        .req_amount(req_amount), .nickel(n0), .dime(d0), .dispense(dispense),
        .done_valid(v0), .done_ok(o0), .done_coins(c0), .done_spent(s0)
    );

    assign req_ready  = sel ? r0 : r1;
    assign nickel     = sel ? n0 : n1;
    assign dime       = sel ? d0 : d1;
    assign done_valid = sel ? v0 : v1;
    assign done_ok    = sel ? o0 : o1;
    assign done_coins = sel ? c0 : c1;
    assign done_spent = sel ? s0 : s1;

    typedef struct {
        bit gap0;
        int amount;
        int price;
        int force_cyc;
        int exp_done;
        int exp_ok;
        int exp_coins;
        int exp_spent;
        int exp_dimes;
        int exp_nickels;
    } vec_t;

    vec_t vecs[11];
    int   last_coins;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int credit = 0, dimes = 0, nickels = 0, overlap = 0;
        int done_cyc = -1, ok = -1, coins = -1, spent = -1;
        bit pend = 0, paid = 0;
        sel        = v.gap0;
        req_amount = 6'(v.amount);
        req_valid  = 1'b1;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
            dispense = pend || (c == v.force_cyc);
            pend = 0;
            if (nickel && dime) overlap++;
            if (dime)   begin dimes++;   credit += 2; end
            if (nickel) begin nickels++; credit += 1; end
            if (v.price > 0 && !paid && credit >= v.price) begin
                pend = 1;
                paid = 1;
            end
            if (done_valid) begin
                done_cyc = c;
                ok       = int'(done_ok);
                coins    = int'(done_coins);
                spent    = int'(done_spent);
            end
            @(posedge clock);
            @(negedge clock);
        end
        dispense = 1'b0;
        check($sformatf("v%0d done_cycle", idx), done_cyc, v.exp_done);
        check($sformatf("v%0d ok", idx), ok, v.exp_ok);
        check($sformatf("v%0d coins", idx), coins, v.exp_coins);
        check($sformatf("v%0d spent", idx), spent, v.exp_spent);
        check($sformatf("v%0d dimes", idx), dimes, v.exp_dimes);
        check($sformatf("v%0d nickels", idx), nickels, v.exp_nickels);
        check($sformatf("v%0d overlap", idx), overlap, 0);
        check($sformatf("v%0d ready_after", idx), int'(req_ready), 1);
        check($sformatf("v%0d coins_hold", idx), int'(done_coins), v.exp_coins);
        if (!v.gap0) last_coins = v.exp_coins;
    endtask

    initial begin
        int bad;
        //            g0 amt pr frc done ok co sp di ni
        vecs[0]  = '{0, 4,  4, 0,  5,  1, 2, 4, 2, 0};
        vecs[1]  = '{0, 3,  0, 0,  12, 0, 2, 3, 1, 1};
        vecs[2]  = '{0, 6,  4, 0,  5,  1, 2, 4, 2, 0};
        vecs[3]  = '{1, 1,  1, 0,  3,  1, 1, 1, 0, 1};
        vecs[4]  = '{0, 0,  0, 0,  1,  0, 0, 0, 0, 0};
        vecs[5]  = '{0, 5,  5, 0,  7,  1, 3, 5, 2, 1};
        vecs[6]  = '{1, 4,  2, 0,  3,  1, 2, 4, 2, 0};
        vecs[7]  = '{0, 1,  0, 9,  10, 1, 1, 1, 0, 1};
        vecs[8]  = '{0, 1,  0, 0,  10, 0, 1, 1, 0, 1};
        vecs[9]  = '{1, 5,  0, 0,  12, 0, 3, 5, 2, 1};
        vecs[10] = '{0, 63, 2, 0,  3,  1, 1, 2, 1, 0};

        reset = 1'b1; req_valid = 1'b0; req_amount = '0; dispense = 1'b0; sel = 1'b0;
        last_coins = 0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst ready", int'(req_ready), 0);
        check("rst pulses", int'(nickel | dime | done_valid | done_ok), 0);
        check("rst coins", int'(done_coins) + int'(done_spent), 0);
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("post_rst ready", int'(req_ready), 1);

        for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

        // Stray dispense while idle must leave every output untouched.
        sel = 1'b0;
        dispense = 1'b1;
        @(posedge clock);
        @(negedge clock);
        dispense = 1'b0;
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            if (!req_ready || nickel || dime || done_valid || int'(done_coins) != last_coins) bad++;
            @(posedge clock);
            @(negedge clock);
        end
        check("idle_dispense", bad, 0);

        // Reset between the two dimes of a 4-unit request aborts it silently.
        req_amount = 6'd4;
        req_valid  = 1'b1;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        check("abort first_dime", int'(dime), 1);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check("abort ready_in_reset", int'(req_ready), 0);
        check("abort coins_cleared", int'(done_coins), 0);
        bad = int'(dime | nickel | done_valid);
        @(posedge clock);
        @(negedge clock);
        check("abort ready_after", int'(req_ready), 1);
        for (int c = 0; c < 12; c++) begin
            if (dime || nickel || done_valid) bad++;
            @(posedge clock);
            @(negedge clock);
        end
        check("abort no_activity", bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/vending_coin_feeder.md
Name: vending_coin_feeder

Overview:
- Customer-side initiator for the nickel/dime/dispense vending machine interface.
- Accepts a purchase request given as an amount in 5-cent units and converts it into single-cycle nickel/dime pulses, dimes first (greedy).
- Watches dispense, stops feeding once it is seen, and reports the outcome with a one-cycle completion pulse.
- Used as a stimulus/driver block in front of vending machine instances in tests and system models.

Parameters:
- AMOUNT_W, 6, width of the request amount and of the spent/coin counters; unit = 5 cents.
- COIN_GAP, 1, idle cycles inserted between consecutive coin pulses; 0 = back-to-back.
- TIMEOUT, 8, cycles to wait for dispense after the last coin before reporting failure; must be >= 1.

Ports:
- clock  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  purchase request valid.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready.
- req_amount  in  AMOUNT_W  amount to feed, in 5-cent units.
- nickel  out  1  one-cycle nickel insert pulse.
- dime  out  1  one-cycle dime insert pulse.
- dispense  in  1  dispense indication from the vending machine.
- done_valid  out  1  one-cycle completion pulse.
- done_ok  out  1  1 = dispense seen; valid with done_valid.
- done_coins  out  AMOUNT_W  number of coins driven for this request.
- done_spent  out  AMOUNT_W  units actually fed (dime = 2, nickel = 1).

Behaviour:
- Reset values: req_ready=0 during reset, then 1 in IDLE. nickel=dime=done_valid=done_ok=0; done_coins=done_spent=0. State=IDLE.
- All outputs are registered.
- nickel and dime are never high in the same cycle.
- States: IDLE, COIN, GAP, WAIT, DONE.
- IDLE:
  - req_ready=1.
  - On accept, latch remaining=req_amount and clear coins/spent.
  - req_amount==0 goes to DONE with ok=0 and no coins driven; otherwise go to COIN.
  - dispense is ignored in IDLE.
- COIN: drive exactly one pulse for one cycle.
  - If remaining>=2: dime, remaining-=2, spent+=2.
  - Else: nickel, remaining-=1, spent+=1.
  - coins+=1.
  - Next state: WAIT if remaining becomes 0; else GAP if COIN_GAP>0; else COIN.
- GAP: count COIN_GAP cycles, then go to COIN.
- Early dispense: dispense high in any cycle of COIN, GAP or WAIT goes to DONE with ok=1 and stops all further coins.
  - If dispense coincides with a COIN cycle, that cycle's coin is still driven and counted; no further coin follows.
- WAIT:
  - Load the counter with TIMEOUT on entry.
  - dispense goes to DONE with ok=1.
  - Counter expiry with no dispense goes to DONE with ok=0.
  - A dispense arriving in the same cycle the counter expires counts as ok=1.
- DONE:
  - done_valid=1 for exactly one cycle, with done_ok, done_coins and done_spent stable in that cycle.
  - Next state is IDLE; req_ready returns the following cycle.
  - Result fields hold their values until the next accept.
- Latency: the machine's dispense appears the cycle after the coin that completes the price. The first coin is driven the cycle after accept.
- Counters saturate and never wrap; spent <= req_amount always.
- Reset asserted mid-operation aborts immediately: outputs return to reset values next cycle, no done_valid for the aborted request.

Test Plan:
- COIN_GAP=1, machine attached, req_amount=4 accepted at cycle 0:
  - dime at cycles 1 and 3, dispense at cycle 4.
  - done_valid at cycle 5 with ok=1, coins=2, spent=4.
- req_amount=3, no dispense ever:
  - dime at cycle 1, nickel at cycle 3.
  - WAIT runs 8 cycles; done_valid with ok=0, coins=2, spent=3.
- req_amount=6, machine attached:
  - dime, dime, then dispense during GAP; third dime never driven.
  - Result ok=1, coins=2, spent=4.
- COIN_GAP=0, req_amount=1: a single nickel in cycle 1, then dispense forced at cycle 2 gives ok=1, coins=1, spent=1.
- req_amount=0 gives done_valid the cycle after accept with ok=0, coins=0 and no coin pulses. A stray dispense pulse while in IDLE causes no output change.
- reset asserted for 1 cycle between the two dimes of a req_amount=4 request:
  - no further coins and no done_valid.
  - req_ready=1 the cycle after reset deasserts.
